// File: rtl/fb_syncfifo_lvl.sv
// Single-clock FIFO with occupancy level, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and optional first-word-fall-through read.
module fb_syncfifo_lvl #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 32,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] in,
    input  logic             pop,
    output logic [WIDTH-1:0] out,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic             aempty,
    output logic [CNT_W-1:0] level,
    input  logic             flush,
    input  logic             clr_err,
    output logic             ovf,
    output logic             udf
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [CNT_W-1:0] level_next;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        push_ok    = push & (~full | pop);
        pop_ok     = pop & ~empty;
        level_next = level + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            afull  <= 1'b0;
            aempty <= 1'b1;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else if (flush) begin
            // Requests in a flush cycle are dropped silently; existing errors persist.
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            afull  <= 1'b0;
            aempty <= 1'b1;
            ovf    <= ovf & ~clr_err;
            udf    <= udf & ~clr_err;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            level  <= level_next;
            full   <= (level_next == CNT_W'(DEPTH));
            empty  <= (level_next == '0);
            afull  <= (level_next >= CNT_W'(AFULL_TH));
            aempty <= (level_next <= CNT_W'(AEMPTY_TH));
            ovf    <= (push & full & ~pop) | (ovf & ~clr_err);
            udf    <= (pop & empty) | (udf & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_ok) mem[wr_ptr] <= in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign out = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [WIDTH-1:0] out_q;
            always_ff @(posedge clk) begin
                if (!rst_n)                out_q <= '0;
                else if (!flush && pop_ok) out_q <= mem[rd_ptr];
            end
            assign out = out_q;
        end
    endgenerate

endmodule

// File: tb/tb_fb_syncfifo_lvl.sv
// Bench for fb_syncfifo_lvl: a standard-read DEPTH=32 instance and an FWFT DEPTH=5 instance
// share one stimulus stream and are checked every cycle against a list-based model.
module tb_fb_syncfifo_lvl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [3:0] din = 4'h0;
    logic       flush = 1'b0;
    logic       clr_err = 1'b0;

    logic [3:0] s_out, f_out;
    logic       s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
    logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [5:0] s_level;
    logic [2:0] f_level;

    int n_chk = 0;
    int n_pass = 0;
    bit armed = 0;

    // Model: each FIFO is an ordered list m_dat[k][0..m_cnt-1], head at index 0.
    logic [3:0] m_dat [2][33];
    int         m_cnt [2];
    bit         m_ovf [2];
    bit         m_udf [2];
    logic [3:0] m_out [2];

    always #5 clk = ~clk;

    fb_syncfifo_lvl u_std (
        .clk(clk), .rst_n(rst_n), .push(push), .in(din), .pop(pop), .out(s_out),
        .full(s_full), .empty(s_empty), .afull(s_afull), .aempty(s_aempty), .level(s_level),
        .flush(flush), .clr_err(clr_err), .ovf(s_ovf), .udf(s_udf)
    );

    fb_syncfifo_lvl #(.DEPTH(5), .FWFT(1)) u_fw (
        .clk(clk), .rst_n(rst_n), .push(push), .in(din), .pop(pop), .out(f_out),
        .full(f_full), .empty(f_empty), .afull(f_afull), .aempty(f_aempty), .level(f_level),
        .flush(flush), .clr_err(clr_err), .ovf(f_ovf), .udf(f_udf)
    );

    function automatic int dep(int k);
        return (k == 0) ? 32 : 5;
    endfunction

    function automatic int afth(int k);
        return (k == 0) ? 30 : 3;
    endfunction

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic mstep(int k);
        int  d;
        bit  f_now, e_now, e_ovf, e_udf;
        d = dep(k);
        if (!rst_n) begin
            m_cnt[k] = 0; m_ovf[k] = 0; m_udf[k] = 0; m_out[k] = 4'h0;
        end else if (flush) begin
            m_cnt[k] = 0;
            if (clr_err) begin m_ovf[k] = 0; m_udf[k] = 0; end
        end else begin
            f_now = (m_cnt[k] == d);
            e_now = (m_cnt[k] == 0);
            e_ovf = push && f_now && !pop;
            e_udf = pop && e_now;
            if (pop && !e_now) begin
                if (k == 0) m_out[k] = m_dat[k][0];
                for (int i = 0; i < m_cnt[k] - 1; i++) m_dat[k][i] = m_dat[k][i+1];
                m_cnt[k]--;
            end
            if (push && (!f_now || pop)) begin
                m_dat[k][m_cnt[k]] = din;
                m_cnt[k]++;
            end
            if (clr_err) begin m_ovf[k] = 0; m_udf[k] = 0; end
            if (e_ovf) m_ovf[k] = 1;
            if (e_udf) m_udf[k] = 1;
        end
    endtask

    always @(posedge clk) begin
        mstep(0);
        mstep(1);
        armed = 1;
    end

    task automatic cmp_inst(int k, string tag, int lvl, int emp, int ful, int af, int ae,
                            int ov, int ud, int o);
        int exp_out;
        if (k == 1) exp_out = (m_cnt[1] == 0) ? 0 : int'(m_dat[1][0]);
        else        exp_out = int'(m_out[0]);
        check({tag, ".level"},  lvl, m_cnt[k]);
        check({tag, ".empty"},  emp, int'(m_cnt[k] == 0));
        check({tag, ".full"},   ful, int'(m_cnt[k] == dep(k)));
        check({tag, ".afull"},  af,  int'(m_cnt[k] >= afth(k)));
        check({tag, ".aempty"}, ae,  int'(m_cnt[k] <= 2));
        check({tag, ".ovf"},    ov,  int'(m_ovf[k]));
        check({tag, ".udf"},    ud,  int'(m_udf[k]));
        check({tag, ".out"},    o,   exp_out);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            cmp_inst(0, "std", int'(s_level), int'(s_empty), int'(s_full), int'(s_afull),
                     int'(s_aempty), int'(s_ovf), int'(s_udf), int'(s_out));
            cmp_inst(1, "fw", int'(f_level), int'(f_empty), int'(f_full), int'(f_afull),
                     int'(f_aempty), int'(f_ovf), int'(f_udf), int'(f_out));
        end
    end

    task automatic cyc(input bit p, input logic [3:0] d, input bit o);
        push = p;
        din  = d;
        pop  = o;
        @(negedge clk);
    endtask

    task automatic clr_cycle();
        clr_err = 1'b1;
        cyc(0, 4'h0, 0);
        clr_err = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst.level", int'(s_level), 0);
        check("rst.empty", int'(s_empty), 1);
        check("rst.aempty", int'(s_aempty), 1);
        check("rst.out", int'(s_out), 0);
        rst_n = 1'b1;

        // Basic push/pop ordering, standard and FWFT read
        cyc(1, 4'h1, 0);
        check("t1.fw_out_first", int'(f_out), 1);
        cyc(1, 4'h2, 0);
        cyc(1, 4'h3, 0);
        check("t1.aempty_lvl3", int'(s_aempty), 0);
        cyc(1, 4'h4, 0);
        check("t1.level4", int'(s_level), 4);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 4'h0, 1);
            check("t1.pop_out", int'(s_out), i);
        end
        cyc(0, 4'h0, 0);
        check("t1.empty_end", int'(s_empty), 1);

        // Fill to full, afull boundary, overflow and clear
        for (int i = 0; i < 32; i++) begin
            cyc(1, 4'(i), 0);
            if (i == 28) check("t2.afull_lvl29", int'(s_afull), 0);
            if (i == 29) check("t2.afull_lvl30", int'(s_afull), 1);
        end
        check("t2.full", int'(s_full), 1);
        cyc(1, 4'hF, 0);
        check("t2.ovf", int'(s_ovf), 1);
        check("t2.level_stays", int'(s_level), 32);
        clr_cycle();
        check("t2.ovf_clr", int'(s_ovf), 0);

        // Full with simultaneous push and pop
        cyc(1, 4'hA, 1);
        check("t3.level", int'(s_level), 32);
        check("t3.ovf", int'(s_ovf), 0);
        check("t3.out_head", int'(s_out), 0);
        for (int i = 0; i < 32; i++) cyc(0, 4'h0, 1);
        check("t3.last_out", int'(s_out), 4'hA);
        cyc(0, 4'h0, 0);
        clr_cycle();

        // Underflow
        cyc(0, 4'h0, 1);
        check("t4.udf", int'(s_udf), 1);
        check("t4.out_hold", int'(s_out), 4'hA);
        clr_cycle();
        cyc(1, 4'h5, 1);
        check("t4.level1", int'(s_level), 1);
        check("t4.udf2", int'(s_udf), 1);
        flush = 1'b1;
        cyc(0, 4'h0, 0);
        flush = 1'b0;
        clr_cycle();

        // FWFT streaming across pointer wrap
        cyc(1, 4'h7, 0);
        check("t5.fw_out7", int'(f_out), 7);
        for (int j = 0; j < 10; j++) begin
            cyc(1, 4'(j + 8), 1);
            check("t5.fw_stream", int'(f_out), (j + 8) & 15);
        end
        cyc(0, 4'h0, 1);
        check("t5.fw_out_empty", int'(f_out), 0);
        check("t5.fw_empty", int'(f_empty), 1);

        // Flush with push+pop, then reset mid-stream
        for (int i = 0; i < 20; i++) cyc(1, 4'(i + 3), 0);
        check("t6.level20", int'(s_level), 20);
        flush = 1'b1;
        cyc(1, 4'h3, 1);
        flush = 1'b0;
        check("t6.flush_level", int'(s_level), 0);
        check("t6.flush_empty", int'(s_empty), 1);
        check("t6.flush_ovf", int'(s_ovf), 0);
        check("t6.flush_udf", int'(s_udf), 0);
        check("t6.fw_ovf_kept", int'(f_ovf), 1);
        cyc(1, 4'hC, 0);
        cyc(1, 4'hD, 0);
        cyc(0, 4'h0, 1);
        rst_n = 1'b0;
        cyc(1, 4'h9, 1);
        check("t6.rst_level", int'(s_level), 0);
        check("t6.rst_out", int'(s_out), 0);
        check("t6.rst_fw_ovf", int'(f_ovf), 0);
        check("t6.rst_fw_out", int'(f_out), 0);
        rst_n = 1'b1;
        cyc(0, 4'h0, 0);
        cyc(0, 4'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
